// File: rtl/floatmul_pkg.sv
// Shared payload types for the float32 multiply datapath.
// The fork and join stages treat the word as opaque bits.
package floatmul_pkg;

  localparam int unsigned EXP_W  = 8;
  localparam int unsigned MANT_W = 23;
  localparam int unsigned WORD_W = 1 + EXP_W + MANT_W;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exponent;
    logic [MANT_W-1:0] mantissa;
  } float32_t;

endpackage

// File: rtl/floatfork_if.sv
// Stream bundle for the float32 fork: one producer side and two consumer branches.
// The slave modport is the fork's own view of the bundle.
interface floatfork_if;
  import floatmul_pkg::*;

  logic     i_valid;
  float32_t i_data;
  logic     i_ready;

  logic     a_valid;
  float32_t a_data;
  logic     a_ready;

  logic     b_valid;
  float32_t b_data;
  logic     b_ready;

  modport master (
    output i_valid, i_data, a_ready, b_ready,
    input  i_ready, a_valid, a_data, b_valid, b_data
  );

  modport slave (
    input  i_valid, i_data, a_ready, b_ready,
    output i_ready, a_valid, a_data, b_valid, b_data
  );

endinterface

// File: rtl/floatfork.sv
// Eager two-way fork: one held float32 word is delivered once to each branch,
// with each branch handshaking independently of the other.
module floatfork
  import floatmul_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  floatfork_if.slave       io,
  output logic             busy,
  output logic [CNT_W-1:0] a_count,
  output logic [CNT_W-1:0] b_count
);

  logic             h_valid_q, h_valid_d;
  float32_t         h_data_q,  h_data_d;
  logic             a_done_q,  a_done_d;
  logic             b_done_q,  b_done_d;
  logic [CNT_W-1:0] a_count_q, a_count_d;
  logic [CNT_W-1:0] b_count_q, b_count_d;

  logic a_valid_c;
  logic b_valid_c;
  logic a_hs_c;
  logic b_hs_c;
  logic retire_c;
  logic i_ready_c;
  logic accept_c;

  // Branch presentation and handshake decode
  always_comb begin
    a_valid_c = h_valid_q & ~a_done_q;
    b_valid_c = h_valid_q & ~b_done_q;
    a_hs_c    = a_valid_c & io.a_ready;
    b_hs_c    = b_valid_c & io.b_ready;
    retire_c  = h_valid_q & (a_done_q | io.a_ready) & (b_done_q | io.b_ready);
    i_ready_c = ~h_valid_q | retire_c;
    accept_c  = io.i_valid & i_ready_c;
  end

  // Hold-stage update; a fresh word wins over retiring the old one
  always_comb begin
    h_valid_d = h_valid_q;
    h_data_d  = h_data_q;
    a_done_d  = a_done_q;
    b_done_d  = b_done_q;
    a_count_d = a_count_q + CNT_W'(a_hs_c);
    b_count_d = b_count_q + CNT_W'(b_hs_c);

    if (accept_c) begin
      h_valid_d = 1'b1;
      h_data_d  = io.i_data;
      a_done_d  = 1'b0;
      b_done_d  = 1'b0;
    end else if (retire_c) begin
      h_valid_d = 1'b0;
      a_done_d  = 1'b0;
      b_done_d  = 1'b0;
    end else begin
      a_done_d  = a_done_q | a_hs_c;
      b_done_d  = b_done_q | b_hs_c;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      h_valid_q <= 1'b0;
      h_data_q  <= '0;
      a_done_q  <= 1'b0;
      b_done_q  <= 1'b0;
      a_count_q <= '0;
      b_count_q <= '0;
    end else begin
      h_valid_q <= h_valid_d;
      h_data_q  <= h_data_d;
      a_done_q  <= a_done_d;
      b_done_q  <= b_done_d;
      a_count_q <= a_count_d;
      b_count_q <= b_count_d;
    end
  end

  assign io.i_ready = i_ready_c;
  assign io.a_valid = a_valid_c;
  assign io.b_valid = b_valid_c;
  assign io.a_data  = h_data_q;
  assign io.b_data  = h_data_q;
  assign busy       = h_valid_q;
  assign a_count    = a_count_q;
  assign b_count    = b_count_q;

endmodule
